io_mmio: RTL
============

IO_MMIO -- requirements
Module: io_mmio

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, depth of each byte FIFO (RX and TX); power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port addr, input, 32 bits: CPU byte address of the load/store in the current cycle.
REQ-005 SHALL have port re, input, 1 bit: CPU load request this cycle.
REQ-006 SHALL have port we, input, 4 bits: CPU store byte enables; any bit set means a store.
REQ-007 SHALL have port din, input, 32 bits: CPU store data.
REQ-008 SHALL have port dout, output, 32 bits: registered load data.
REQ-009 SHALL have port inst_retired, input, 1 bit: one-cycle pulse per retired instruction.
REQ-010 SHALL have ports uart_rx_data (input, 8 bits), uart_rx_valid (input, 1 bit) and uart_rx_ready (output, 1 bit): byte stream from the UART receiver.
REQ-011 SHALL have ports uart_tx_data (output, 8 bits), uart_tx_valid (output, 1 bit) and uart_tx_ready (input, 1 bit): byte stream to the UART transmitter.

Function
REQ-012 SHALL decode only when addr[31:28]==4'h8, as follows:
- 0x80000000: status, read-only; bit0 = TX FIFO not full, bit1 = RX FIFO not empty, all other bits 0.
- 0x80000004: RX data, read-only.
- 0x80000008: TX data, write-only.
- 0x80000010: cycle counter, read-only.
- 0x80000014: instruction counter, read-only.
- 0x80000018: counter reset, write-only.
REQ-013 SHALL present load data on dout exactly one cycle after the re cycle, and SHALL hold dout until the next re.
REQ-014 SHALL return 0 for loads from unmapped or write-only addresses; stores to unmapped or read-only addresses SHALL have no effect.
REQ-015 SHALL, on a load from 0x80000004 with the RX FIFO non-empty, return {24'b0, head byte} and pop the head in the same request cycle.
REQ-016 SHALL, on a load from 0x80000004 with the RX FIFO empty, return 0 and not pop.
REQ-017 SHALL, on a store to 0x80000008, push din[7:0] into the TX FIFO if it is not full at the start of the cycle; otherwise the byte is silently dropped.
REQ-018 SHALL drive uart_rx_ready = RX FIFO not full; a byte SHALL be accepted on a cycle with uart_rx_valid && uart_rx_ready.
REQ-019 SHALL drive uart_tx_valid = TX FIFO not empty and uart_tx_data = TX head byte; the head SHALL pop on a cycle with uart_tx_valid && uart_tx_ready.
REQ-020 SHALL allow push and pop on the same FIFO in the same cycle: the occupancy count is unchanged and order is preserved.
- Full and empty SHALL be evaluated from start-of-cycle state.
- Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 SHALL increment the 32-bit cycle counter every cycle rst is low, wrapping 0xFFFFFFFF to 0.
REQ-022 SHALL increment the 32-bit instruction counter on each cycle with inst_retired high, wrapping the same way.
REQ-023 SHALL clear both counters to 0 on the cycle after a store to 0x80000018; the clear SHALL win over a simultaneous increment.
REQ-024 SHALL, when re and we are both active in the same cycle, execute the load and the store independently.
REQ-025 SHALL return the pre-update value when a load and a same-cycle update target the same state.

Reset
REQ-026 SHALL, while rst is high, empty both FIFOs and zero both counters and dout.
REQ-027 SHALL hold uart_tx_valid=0, uart_tx_data=0 and uart_rx_ready=0 while rst is high; rst is not itself counted as a cycle.
REQ-028 SHALL discard all in-flight bytes when reset is asserted mid-transfer; the first cycle after rst falls SHALL show uart_rx_ready=1, uart_tx_valid=0 and cycle counter=0.

Verification
REQ-029 SHALL cover loopback: store 0x41 to 0x80000008 with uart_tx_ready=1 -> uart_tx_valid=1 with uart_tx_data=0x41 on the next cycle, and the FIFO empty after the handshake.
REQ-030 SHALL cover RX: drive 0x5A with uart_rx_valid for one cycle; load 0x80000000 -> dout=0x2 or 0x3; load 0x80000004 -> dout=0x0000005A; a repeat load of 0x80000004 -> dout=0.
REQ-031 SHALL cover TX full: hold uart_tx_ready=0 and store 10 bytes 0..9 -> status bit0=0 after 8 stores; on release exactly bytes 0..7 emerge in order.
REQ-032 SHALL cover counters: after 100 cycles out of reset with inst_retired pulsed 37 times -> loads of 0x80000010 and 0x80000014 read 100±1 and 37; store to 0x80000018 -> both read small values below 3 immediately after.
REQ-033 SHALL cover simultaneous FIFO events: with the RX FIFO at 8 entries, pop via load in the same cycle uart_rx_valid=1 -> the new byte is not accepted (ready was 0); with 7 entries, push and pop in the same cycle -> count stays 7 and order is preserved.
REQ-034 SHALL cover mid-operation reset: assert rst with 3 bytes queued in each FIFO -> the cycle after rst falls shows uart_tx_valid=0, status reads 0x1, and the RX load returns 0.

Source files
------------

// File: rtl/io_mmio.sv
// Memory-mapped I/O block: UART RX/TX byte FIFOs plus cycle and retired-instruction
// counters, reached through a single-cycle CPU load/store port with registered read data.

module io_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   // Full/empty come from registered occupancy, so both reflect start-of-cycle state.
   assign full    = (cnt_q == DEPTH_C);
   assign empty   = (cnt_q == '0);
   assign head    = mem_q[rd_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      mem_d = mem_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (push_ok) begin
         mem_d[wr_q] = wdata;
         wr_d        = wr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_d = rd_q + PW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

module io_mmio #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        re,
   input  logic [3:0]  we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic        inst_retired,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready
);
   localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
   localparam logic [31:0] ADDR_RXDATA = 32'h8000_0004;
   localparam logic [31:0] ADDR_TXDATA = 32'h8000_0008;
   localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0010;
   localparam logic [31:0] ADDR_INST   = 32'h8000_0014;
   localparam logic [31:0] ADDR_CLR    = 32'h8000_0018;

   logic        store;
   logic        rx_push, rx_pop, rx_full, rx_empty;
   logic        tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]  rx_head, tx_head;
   logic        cnt_clr;
   logic [31:0] cyc_q, cyc_d, inst_q, inst_d, dout_q, dout_d, rdata;
   logic        unused_din;

   assign unused_din = ^din[31:8];
   assign store      = |we;

   // Stream handshakes: a byte moves on any cycle where valid and ready are both high;
   // both sides are held idle while rst is asserted.
   assign uart_rx_ready = !rst && !rx_full;
   assign uart_tx_valid = !rst && !tx_empty;
   assign uart_tx_data  = rst ? 8'h00 : tx_head;

   assign rx_push = uart_rx_valid && uart_rx_ready;
   assign rx_pop  = re && (addr == ADDR_RXDATA);
   assign tx_push = store && (addr == ADDR_TXDATA);
   assign tx_pop  = uart_tx_valid && uart_tx_ready;
   assign cnt_clr = store && (addr == ADDR_CLR);

   io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .wdata (uart_rx_data),
      .pop   (rx_pop),
      .head  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .wdata (din[7:0]),
      .pop   (tx_pop),
      .head  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   // Read mux sees pre-update state, so a load racing an update returns the old value.
   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_STATUS: rdata = {30'b0, !rx_empty, !tx_full};
         ADDR_RXDATA: rdata = rx_empty ? 32'h0 : {24'b0, rx_head};
         ADDR_CYCLE:  rdata = cyc_q;
         ADDR_INST:   rdata = inst_q;
         default:     rdata = '0;
      endcase
   end

   always_comb begin
      cyc_d  = cyc_q + 32'd1;
      inst_d = inst_retired ? inst_q + 32'd1 : inst_q;
      dout_d = re ? rdata : dout_q;
      if (cnt_clr) begin
         cyc_d  = '0;
         inst_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         inst_q <= '0;
         dout_q <= '0;
      end else begin
         cyc_q  <= cyc_d;
         inst_q <= inst_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;
endmodule
